// File: rtl/column_window_feeder.sv
// column_window_feeder: raster luma stream to WINDOW_SIZE_Y-tall columns, with a
// WINDOW_SIZE_X-beat peek column and a per-row restart strobe for window consumers.
module column_window_feeder #(
  parameter int LUMA_BITS     = 8,
  parameter int WINDOW_SIZE_X = 31,
  parameter int WINDOW_SIZE_Y = 31,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      in_valid,
  input  logic                                      in_frame_start,
  input  logic [LUMA_BITS-1:0]                      in_luma,
  output logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]   out_column,
  output logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]   out_peek_column,
  output logic                                      out_valid,
  output logic                                      out_reset
);
  localparam int XW = IMAGE_WIDTH > 1 ? $clog2(IMAGE_WIDTH) : 1;
  localparam int YW = IMAGE_HEIGHT > 1 ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int LB = WINDOW_SIZE_Y > 1 ? WINDOW_SIZE_Y - 1 : 1;
  localparam int SW = LB > 1 ? $clog2(LB) : 1;
  typedef logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0] col_t;
  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;
  logic [SW-1:0] s_q, s_d, ps;
  logic [LUMA_BITS-1:0] mem [LB][IMAGE_WIDTH];
  col_t col_d, col_q, peek_q;
  col_t dl_q [WINDOW_SIZE_X];
  logic valid_q, reset_q, row_end, emit;
  assign out_column      = col_q;
  assign out_peek_column = peek_q;
  assign out_valid       = valid_q;
  assign out_reset       = reset_q;
  // s tracks y mod (WINDOW_SIZE_Y-1): the line-buffer slot owned by the current row
  always_comb begin
    px      = in_frame_start ? '0 : x_q;
    py      = in_frame_start ? '0 : y_q;
    ps      = in_frame_start ? '0 : s_q;
    row_end = px == XW'(IMAGE_WIDTH - 1);
    x_d     = row_end ? '0 : px + XW'(1);
    y_d     = row_end ? (py == YW'(IMAGE_HEIGHT - 1) ? '0 : py + YW'(1)) : py;
    s_d     = row_end ? ((py == YW'(IMAGE_HEIGHT - 1) || ps == SW'(LB - 1)) ? '0 : ps + SW'(1)) : ps;
    emit    = py >= YW'(WINDOW_SIZE_Y - 1);
  end
  assign col_d[WINDOW_SIZE_Y-1] = in_luma;
  for (genvar k = 0; k < WINDOW_SIZE_Y - 1; k++) begin : g_rd
    logic [SW:0] sum;
    assign sum      = {1'b0, ps} + (SW+1)'(k);
    assign col_d[k] = mem[sum >= (SW+1)'(LB) ? SW'(sum - (SW+1)'(LB)) : sum[SW-1:0]][px];
  end
  always_ff @(posedge clk)
    if (in_valid) mem[ps][px] <= in_luma;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      col_q   <= '0;
      peek_q  <= '0;
      valid_q <= 1'b0;
      reset_q <= 1'b0;
      for (int i = 0; i < WINDOW_SIZE_X; i++) dl_q[i] <= '0;
    end else begin
      valid_q <= in_valid && emit;
      reset_q <= in_valid && emit && px == '0;
      if (in_valid) begin
        x_q   <= x_d;
        y_q   <= y_d;
        s_q   <= s_d;
        col_q <= col_d;
      end
      // the x==0 beat restarts the delay line, keeping only its own column
      if (in_valid && emit) begin
        peek_q  <= px == '0 ? '0 : dl_q[WINDOW_SIZE_X-1];
        dl_q[0] <= col_d;
        for (int i = 1; i < WINDOW_SIZE_X; i++) dl_q[i] <= px == '0 ? '0 : dl_q[i-1];
      end
    end
endmodule

// File: tb/tb_column_window_feeder.sv
// tb_column_window_feeder: constant table for a full frame, hand-written corner
// sequences, and randomized traffic checked against a position-indexed image model.
module tb_column_window_feeder;
  localparam int LB = 8, WX = 3, WY = 3, IW = 4, IH = 4;
  typedef logic [WY-1:0][LB-1:0] col_t;
  typedef struct {
    bit v, fs;
    logic [LB-1:0] l;
    bit ev, er;
    col_t c, p;
  } vec_t;
  logic clk = 0, reset_n = 0, in_valid = 0, in_frame_start = 0;
  logic [LB-1:0] in_luma = '0;
  col_t out_column, out_peek_column;
  logic out_valid, out_reset;
  int tests = 0, fails = 0;
  int mx, my;
  logic [LB-1:0] img [IH][IW];
  col_t rowcol [IW];
  col_t e_col, e_peek;
  bit known;
  vec_t tbl [IW*IH];
  column_window_feeder #(.LUMA_BITS(LB), .WINDOW_SIZE_X(WX), .WINDOW_SIZE_Y(WY),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_frame_start(in_frame_start),
    .in_luma(in_luma), .out_column(out_column), .out_peek_column(out_peek_column),
    .out_valid(out_valid), .out_reset(out_reset));
  always #5 clk = ~clk;
  function automatic logic [LB-1:0] pix(input int x, input int y);
    return LB'(16 * y + x);
  endfunction
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic beat(input bit v, input bit fs, input logic [LB-1:0] l);
    bit ev, er;
    col_t c, p;
    ev = 0; er = 0; c = '0; p = '0;
    if (v) begin
      if (fs) begin mx = 0; my = 0; end
      ev = my >= WY - 1;
      er = ev && mx == 0;
      for (int k = 0; k < WY; k++)
        c[k] = (k == WY - 1) ? l : (ev ? img[my-(WY-1)+k][mx] : '0);
      img[my][mx] = l;
      if (ev) begin
        rowcol[mx] = c;
        p = mx >= WX ? rowcol[mx-WX] : '0;
        e_col = c; e_peek = p; known = 1;
      end else known = 0;
      mx++;
      if (mx == IW) begin mx = 0; my = (my + 1) % IH; end
    end
    in_valid = v; in_frame_start = fs; in_luma = l;
    @(posedge clk); #1;
    chk("valid", 64'(out_valid), 64'(ev));
    chk("reset", 64'(out_reset), 64'(er));
    if (known) begin
      chk("column", 64'(out_column), 64'(e_col));
      chk("peek", 64'(out_peek_column), 64'(e_peek));
    end
  endtask
  task automatic check_zero(input string n);
    chk({n, "_valid"}, 64'(out_valid), 64'd0);
    chk({n, "_reset"}, 64'(out_reset), 64'd0);
    chk({n, "_column"}, 64'(out_column), 64'd0);
    chk({n, "_peek"}, 64'(out_peek_column), 64'd0);
  endtask
  task automatic do_reset();
    #3 reset_n = 0;
    #1 check_zero("async_rst");
    mx = 0; my = 0; known = 1; e_col = '0; e_peek = '0;
    in_valid = 0; in_frame_start = 0;
    @(negedge clk) reset_n = 1;
  endtask
  task automatic run_table();
    for (int i = 0; i < IW * IH; i++) begin
      in_valid = tbl[i].v; in_frame_start = tbl[i].fs; in_luma = tbl[i].l;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_reset", i), 64'(out_reset), 64'(tbl[i].er));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_column", i), 64'(out_column), 64'(tbl[i].c));
        chk($sformatf("tbl%0d_peek", i), 64'(out_peek_column), 64'(tbl[i].p));
      end
    end
    in_valid = 0; in_frame_start = 0;
    mx = 0; my = 0; known = 0;
  endtask
  task automatic frame_rows(input int n);
    for (int y = 0; y < n; y++)
      for (int x = 0; x < IW; x++) beat(1, y == 0 && x == 0, pix(x, y));
  endtask
  initial begin
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) begin
        int i;
        i = y * IW + x;
        tbl[i].v  = 1;
        tbl[i].fs = i == 0;
        tbl[i].l  = pix(x, y);
        tbl[i].ev = y >= WY - 1;
        tbl[i].er = y >= WY - 1 && x == 0;
        tbl[i].c  = y >= WY - 1 ? {pix(x, y), pix(x, y - 1), pix(x, y - 2)} : '0;
        tbl[i].p  = (y >= WY - 1 && x >= WX) ? {pix(x - WX, y), pix(x - WX, y - 1), pix(x - WX, y - 2)} : '0;
      end
    #12 check_zero("por");
    @(negedge clk) reset_n = 1;
    mx = 0; my = 0; known = 1; e_col = '0; e_peek = '0;
    run_table();
    frame_rows(2);
    beat(1, 0, pix(0, 2));
    chk("s4_x0_col", 64'(out_column), 64'h201000);
    beat(0, 0, 8'hAA);
    chk("s4_bubble_hold", 64'(out_column), 64'h201000);
    beat(1, 0, pix(1, 2));
    beat(0, 0, 8'h55);
    beat(1, 0, pix(2, 2));
    beat(1, 0, pix(3, 2));
    chk("s4_x3_col", 64'(out_column), 64'h231303);
    chk("s4_x3_peek", 64'(out_peek_column), 64'h201000);
    beat(1, 0, pix(0, 3));
    chk("s3_r3x0_col", 64'(out_column), 64'h302010);
    chk("s3_r3x0_reset", 64'(out_reset), 64'd1);
    chk("s3_r3x0_peek", 64'(out_peek_column), 64'd0);
    for (int x = 1; x < IW; x++) beat(1, 0, pix(x, 3));
    chk("s3_r3x3_peek", 64'(out_peek_column), 64'h302010);
    frame_rows(2);
    beat(1, 0, pix(0, 2));
    beat(1, 1, pix(0, 0));
    for (int x = 1; x < IW; x++) beat(1, 0, pix(x, 0));
    for (int x = 0; x < IW; x++) beat(1, 0, pix(x, 1));
    beat(1, 0, pix(0, 2));
    chk("s5_first_col", 64'(out_column), 64'h201000);
    chk("s5_first_reset", 64'(out_reset), 64'd1);
    frame_rows(3);
    beat(1, 0, pix(0, 3));
    beat(1, 0, pix(1, 3));
    do_reset();
    run_table();
    for (int i = 0; i < 600; i++) begin
      bit v, fs;
      v  = i == 0 || $urandom_range(0, 3) != 0;
      fs = v && (i == 0 || $urandom_range(0, 40) == 0);
      beat(v, fs, LB'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
